// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared state encoding and default sizes for the scan test controller
package scan_ctrl_pkg;

  localparam int DEF_CHAIN_LEN = 3;
  localparam int DEF_CAP_W     = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    COMPARE   = 3'd4
  } state_e;

endpackage

// File: rtl/scan_test_controller_if.sv
// rtl/scan_test_controller_if.sv - tester and scan-pin signals between test logic and the controller
interface scan_test_controller_if #(
  parameter int CHAIN_LEN = 3,
  parameter int CAP_W     = 4
);

  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CHAIN_LEN-1:0] expected;
  logic [CHAIN_LEN-1:0] cmp_mask;
  logic [CAP_W-1:0]     capture_cycles;
  logic                 scan_out;
  logic                 SE;
  logic                 SD;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] response;

  modport master (
    output start, abort, pattern, expected, cmp_mask, capture_cycles, scan_out,
    input  SE, SD, busy, done, pass, response
  );

  modport slave (
    input  start, abort, pattern, expected, cmp_mask, capture_cycles, scan_out,
    output SE, SD, busy, done, pass, response
  );

endinterface

// File: rtl/scan_bit_counter.sv
// rtl/scan_bit_counter.sv - loadable down-counter with zero flag, used for shift and capture counts
module scan_bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/scan_test_controller.sv
// rtl/scan_test_controller.sv - sequences shift-in, capture, shift-out and masked compare on a mux-scan chain
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CAP_W     = DEF_CAP_W
) (
  input logic                   clk,
  input logic                   rst_n,
  scan_test_controller_if.slave bus
);

  localparam int SW = $clog2(CHAIN_LEN + 1);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_SHIFT_IN  = SHIFT_IN;
  localparam logic [2:0] S_CAPTURE   = CAPTURE;
  localparam logic [2:0] S_SHIFT_OUT = SHIFT_OUT;
  localparam logic [2:0] S_COMPARE   = COMPARE;

  logic [2:0]           state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d, exp_q, exp_d, mask_q, mask_d, resp_q, resp_d;
  logic [CAP_W-1:0]     cap_q, cap_d;
  logic                 se_q, se_d, sd_q, sd_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                 cnt_clr, sh_load, sh_dec, sh_zero, cap_load, cap_dec, cap_zero;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    exp_d    = exp_q;
    mask_d   = mask_q;
    cap_d    = cap_q;
    resp_d   = resp_q;
    se_d     = se_q;
    sd_d     = sd_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    sh_load  = 1'b0;
    sh_dec   = 1'b0;
    cap_load = 1'b0;
    cap_dec  = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      se_d    = 1'b0;
      sd_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          se_d = 1'b0;
          sd_d = 1'b0;
          if (done_q) busy_d = 1'b0;
          // busy_q stays high through the done cycle, which blocks a start there
          if (bus.start && !busy_q) begin
            pat_d   = bus.pattern << 1;
            exp_d   = bus.expected;
            mask_d  = bus.cmp_mask;
            cap_d   = bus.capture_cycles;
            sd_d    = bus.pattern[CHAIN_LEN-1];
            se_d    = 1'b1;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            resp_d  = '0;
            sh_load = 1'b1;
            state_d = S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          sh_dec = 1'b1;
          if (sh_zero) begin
            sd_d = 1'b0;
            if (cap_q != '0) begin
              se_d     = 1'b0;
              cap_load = 1'b1;
              state_d  = S_CAPTURE;
            end else begin
              sh_load = 1'b1;
              state_d = S_SHIFT_OUT;
            end
          end else begin
            sd_d  = pat_q[CHAIN_LEN-1];
            pat_d = pat_q << 1;
          end
        end
        S_CAPTURE: begin
          cap_dec = 1'b1;
          if (cap_zero) begin
            se_d    = 1'b1;
            sh_load = 1'b1;
            state_d = S_SHIFT_OUT;
          end
        end
        S_SHIFT_OUT: begin
          sh_dec = 1'b1;
          // first sample is the last flop, so shifting left lands it in the MSB
          resp_d = (resp_q << 1) | CHAIN_LEN'(bus.scan_out);
          if (sh_zero) begin
            se_d    = 1'b0;
            state_d = S_COMPARE;
          end
        end
        S_COMPARE: begin
          pass_d  = (((resp_q ^ exp_q) & mask_q) == '0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  scan_bit_counter #(.W(SW)) u_shift_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (sh_load),
    .load_val (SW'(CHAIN_LEN - 1)),
    .dec      (sh_dec),
    .zero     (sh_zero)
  );

  scan_bit_counter #(.W(CAP_W)) u_cap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cap_load),
    .load_val (cap_q - 1'b1),
    .dec      (cap_dec),
    .zero     (cap_zero)
  );

  assign bus.SE       = se_q;
  assign bus.SD       = sd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.response = resp_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// tb/tb_scan_test_controller.sv - directed bench for scan_test_controller against a 3-flop inverting mux-scan chain
module tb_scan_test_controller;
  import scan_ctrl_pkg::*;

  localparam int CL = DEF_CHAIN_LEN;
  localparam int CW = DEF_CAP_W;

  typedef struct {
    logic [CL-1:0] pattern;
    logic [CL-1:0] expected;
    logic [CL-1:0] mask;
    logic [CW-1:0] cap;
    logic [CL-1:0] resp;
    logic          pass;
    int            latency;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  vec_t vecs[6];
  logic se_log[64];
  logic sd_log[64];
  logic [CL-1:0] chain = '0;

  scan_test_controller_if #(.CHAIN_LEN(CL), .CAP_W(CW)) bus ();

  scan_test_controller #(.CHAIN_LEN(CL), .CAP_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // chain model: shift on SE=1, functional D = ~Q on SE=0
  always @(posedge clk) chain <= bus.SE ? {chain[CL-2:0], bus.SD} : ~chain;
  assign bus.scan_out = chain[CL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  cyc;
    int  se0;
    bit  got;
    bus.pattern        = v.pattern;
    bus.expected       = v.expected;
    bus.cmp_mask       = v.mask;
    bus.capture_cycles = v.cap;
    bus.start          = 1'b1;
    @(posedge clk); #1;
    bus.start          = 1'b0;
    bus.pattern        = ~v.pattern;
    bus.expected       = ~v.expected;
    bus.cmp_mask       = '0;
    bus.capture_cycles = v.cap + 4'd3;
    check({tag, "_resp_clr"}, 32'(bus.response), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    se_log[0] = bus.SE;
    sd_log[0] = bus.SD;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      se_log[cyc] = bus.SE;
      sd_log[cyc] = bus.SD;
      if (bus.done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc + 1), 32'(v.latency));
    check({tag, "_sd_seq"}, 32'({sd_log[0], sd_log[1], sd_log[2]}), 32'(v.pattern));
    check({tag, "_se_shift_in"}, 32'({se_log[0], se_log[1], se_log[2]}), 32'b111);
    se0 = 0;
    for (int i = 3; i <= cyc - 2; i++) if (!se_log[i]) se0++;
    check({tag, "_cap_cycles"}, 32'(se0), 32'(v.cap));
    check({tag, "_response"}, 32'(bus.response), 32'(v.resp));
    check({tag, "_pass"}, 32'(bus.pass), 32'(v.pass));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int hits;
    bit got;

    vecs[0] = '{pattern: 3'b101, expected: 3'b101, mask: 3'b111, cap: 4'd0, resp: 3'b101, pass: 1'b1, latency: 8};
    vecs[1] = '{pattern: 3'b110, expected: 3'b001, mask: 3'b111, cap: 4'd1, resp: 3'b001, pass: 1'b1, latency: 9};
    vecs[2] = '{pattern: 3'b110, expected: 3'b011, mask: 3'b101, cap: 4'd1, resp: 3'b001, pass: 1'b1, latency: 9};
    vecs[3] = '{pattern: 3'b110, expected: 3'b011, mask: 3'b111, cap: 4'd1, resp: 3'b001, pass: 1'b0, latency: 9};
    vecs[4] = '{pattern: 3'b010, expected: 3'b100, mask: 3'b110, cap: 4'd3, resp: 3'b101, pass: 1'b1, latency: 11};
    vecs[5] = '{pattern: 3'b011, expected: 3'b011, mask: 3'b111, cap: 4'd2, resp: 3'b011, pass: 1'b1, latency: 10};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern = '0;
    bus.expected = '0;
    bus.cmp_mask = '0;
    bus.capture_cycles = '0;

    #12;
    check("rst_se", 32'(bus.SE), 32'd0);
    check("rst_sd", 32'(bus.SD), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pass", 32'(bus.pass), 32'd0);
    check("rst_response", 32'(bus.response), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // abort in the 2nd capture cycle of a 3-cycle capture
    bus.pattern = 3'b010;
    bus.expected = 3'b101;
    bus.cmp_mask = 3'b111;
    bus.capture_cycles = 4'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_capture", 32'(bus.SE), 32'd0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_se", 32'(bus.SE), 32'd0);
    check("abort_sd", 32'(bus.SD), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    hits = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) hits++;
    end
    check("abort_no_done", 32'(hits), 32'd0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_beats_start_busy", 32'(bus.busy), 32'd0);
    check("abort_beats_start_se", 32'(bus.SE), 32'd0);

    run_vec(vecs[5], "post_abort");

    // asynchronous reset in the middle of shift-out
    bus.pattern = 3'b101;
    bus.expected = 3'b101;
    bus.cmp_mask = 3'b111;
    bus.capture_cycles = 4'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_se", 32'(bus.SE), 32'd0);
    check("mid_rst_sd", 32'(bus.SD), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_pass", 32'(bus.pass), 32'd0);
    check("mid_rst_response", 32'(bus.response), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start held through the whole test, including the done cycle
    bus.pattern = 3'b110;
    bus.expected = 3'b001;
    bus.cmp_mask = 3'b111;
    bus.capture_cycles = 4'd1;
    bus.start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) got = 1'b1;
    end
    check("held_done_seen", 32'(got), 32'd1);
    check("held_latency", 32'(cyc), 32'd9);
    check("held_response", 32'(bus.response), 32'b001);
    check("held_pass", 32'(bus.pass), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("held_busy_after_done", 32'(bus.busy), 32'd0);
    hits = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.SE) hits++;
    end
    check("held_no_second_test", 32'(hits), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
